brq_muldiv_iter: RTL

BRQ_MULDIV_ITER -- requirements
Module: brq_muldiv_iter

---
 rtl/brq_muldiv_iter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/brq_muldiv_iter.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, one step per cycle, with zero/overflow fast paths resolved at acceptance.
module brq_muldiv_iter #(
    parameter int DataWidth    = 32,
    parameter int RegAddrWidth = 5,
    parameter int EarlyOut     = 1
) (
    input  logic                    brq_clk,
    input  logic                    brq_rst,
    input  logic                    md_start,
    input  logic [2:0]              md_op,
    input  logic [DataWidth-1:0]    md_op_a,
    input  logic [DataWidth-1:0]    md_op_b,
    input  logic [RegAddrWidth-1:0] md_rd_in,
    input  logic                    md_kill,
    input  logic                    md_ready,
    output logic                    md_busy,
    output logic                    md_valid,
    output logic [DataWidth-1:0]    md_result,
    output logic [RegAddrWidth-1:0] md_rd
);

    localparam int CntW = $clog2(DataWidth) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

    state_e state, state_nxt;

    logic [CntW-1:0]         cnt;
    logic [2:0]              op_q;
    logic                    neg_q;
    logic [DataWidth-1:0]    m_q;
    logic [2*DataWidth-1:0]  acc_q;
    logic [RegAddrWidth-1:0] rd_q;

    logic                    accept;
    logic                    is_div;
    logic                    a_neg, b_neg;
    logic                    div_zero, div_ovf, mul_zero, special;
    logic [DataWidth-1:0]    mag_a, mag_b, special_res;
    logic [DataWidth:0]      mul_sum, div_shift, div_diff;
    logic [2*DataWidth-1:0]  acc_step, prod_s;
    logic [DataWidth-1:0]    quo_s, rem_s, fix_res;

    function automatic logic [DataWidth-1:0] neg_w(input logic [DataWidth-1:0] v,
                                                   input logic                 en);
        logic signed [DataWidth-1:0] sv;
        sv = v;
        return en ? -sv : sv;
    endfunction

    function automatic logic [2*DataWidth-1:0] neg_2w(input logic [2*DataWidth-1:0] v,
                                                      input logic                   en);
        logic signed [2*DataWidth-1:0] sv;
        sv = v;
        return en ? -sv : sv;
    endfunction

    // Acceptance decode: operand magnitudes, result sign and fast-path detection
    always_comb begin
        logic a_signed, b_signed;
        is_div   = md_op[2];
        a_signed = (md_op == 3'b001) || (md_op == 3'b010) || (md_op == 3'b100) || (md_op == 3'b110);
        b_signed = (md_op == 3'b001) || (md_op == 3'b100) || (md_op == 3'b110);
        a_neg    = a_signed & md_op_a[DataWidth-1];
        b_neg    = b_signed & md_op_b[DataWidth-1];
        mag_a    = neg_w(md_op_a, a_neg);
        mag_b    = neg_w(md_op_b, b_neg);
        accept   = md_start && (state == IDLE) && !md_kill;
        div_zero = is_div && (md_op_b == '0);
        div_ovf  = is_div && !md_op[0] && (md_op_a == {1'b1, {(DataWidth-1){1'b0}}}) && (md_op_b == '1);
        mul_zero = (EarlyOut != 0) && !is_div && ((md_op_a == '0) || (md_op_b == '0));
        special  = div_zero || div_ovf || mul_zero;
        if (div_zero)     special_res = md_op[1] ? md_op_a : '1;
        else if (div_ovf) special_res = md_op[1] ? '0 : md_op_a;
        else              special_res = '0;
    end

    // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*DataWidth-1:DataWidth]} + (acc_q[0] ? {1'b0, m_q} : '0);
        div_shift = acc_q[2*DataWidth-1:DataWidth-1];
        div_diff  = div_shift - {1'b0, m_q};
        if (!op_q[2])
            acc_step = {mul_sum, acc_q[DataWidth-1:1]};
        else if (div_diff[DataWidth])
            acc_step = {div_shift[DataWidth-1:0], acc_q[DataWidth-2:0], 1'b0};
        else
            acc_step = {div_diff[DataWidth-1:0], acc_q[DataWidth-2:0], 1'b1};
    end

    // Sign fix-up and half selection
    always_comb begin
        prod_s = neg_2w(acc_q, neg_q);
        quo_s  = neg_w(acc_q[DataWidth-1:0], neg_q);
        rem_s  = neg_w(acc_q[2*DataWidth-1:DataWidth], neg_q);
        if (op_q[2])                fix_res = op_q[1] ? rem_s : quo_s;
        else if (op_q[1:0] == 2'b00) fix_res = prod_s[DataWidth-1:0];
        else                        fix_res = prod_s[2*DataWidth-1:DataWidth];
    end

    always_ff @(posedge brq_clk) begin
        if (!brq_rst) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept)                         state_nxt = special ? DONE : CALC;
            CALC: if (md_kill)                        state_nxt = IDLE;
                  else if (cnt == CntW'(1))           state_nxt = FIX;
            FIX:  state_nxt = md_kill ? IDLE : DONE;
            DONE: if (md_kill || md_ready)            state_nxt = IDLE;
            default:                                  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        md_busy  = 1'b0;
        md_valid = 1'b0;
        if (state != IDLE) md_busy  = 1'b1;
        if (state == DONE) md_valid = 1'b1;
    end

    always_ff @(posedge brq_clk) begin
        if (!brq_rst) begin
            cnt       <= '0;
            md_result <= '0;
            md_rd     <= '0;
        end else begin
            if (accept && !special)
                cnt <= CntW'(DataWidth);
            else if (state == CALC)
                cnt <= md_kill ? '0 : cnt - CntW'(1);
            if (accept && special) begin
                md_result <= special_res;
                md_rd     <= md_rd_in;
            end else if (state == FIX && !md_kill) begin
                md_result <= fix_res;
                md_rd     <= rd_q;
            end
        end
    end

    // Operand/accumulator datapath carries no reset; control qualifies it
    always_ff @(posedge brq_clk) begin
        if (accept) begin
            op_q  <= md_op;
            neg_q <= (md_op[2] && md_op[1]) ? a_neg : (a_neg ^ b_neg);
            m_q   <= is_div ? mag_b : mag_a;
            acc_q <= {{DataWidth{1'b0}}, (is_div ? mag_a : mag_b)};
            rd_q  <= md_rd_in;
        end else if (state == CALC) begin
            acc_q <= acc_step;
        end
    end

endmodule
